// File: rtl/solve_scheduler.sv
// solve_scheduler: feeds queued boards into a multithreaded solver pipeline
// and returns tagged scores through a credit-protected result FIFO.
module solve_scheduler #(
   parameter int IDEPTH  = 4,
   parameter int NTHREAD = 7,
   parameter int ODEPTH  = 8
) (
   input  logic              iCLOCK,
   input  logic              iRESET,
   input  logic              run,
   input  logic              t_valid,
   output logic              t_ready,
   input  logic [63:0]       t_player,
   input  logic [63:0]       t_opponent,
   input  logic [3:0]        t_tag,
   output logic              p_enable,
   output logic [63:0]       p_player,
   output logic [63:0]       p_opponent,
   input  logic              p_solved,
   input  logic [4:0]        p_thread,
   input  logic signed [7:0] p_res,
   output logic              r_valid,
   input  logic              r_ready,
   output logic [3:0]        r_tag,
   output logic signed [7:0] r_res,
   output logic              busy
);
   localparam int IAW = (IDEPTH > 1) ? $clog2(IDEPTH) : 1;
   localparam int OAW = (ODEPTH > 1) ? $clog2(ODEPTH) : 1;
   localparam int ICW = IAW + 1;
   localparam int OCW = OAW + 1;
   localparam int TW  = (NTHREAD > 1) ? $clog2(NTHREAD) : 1;
   localparam int SW  = $clog2(ODEPTH + NTHREAD + 1) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_RUN
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [TW-1:0]      r_cnt;
   logic               r_pen;
   logic               r_rdy;
   logic [NTHREAD-1:0] r_live;
   logic [3:0]         r_tagm [NTHREAD];

   logic [63:0]        r_tpl [IDEPTH];
   logic [63:0]        r_top [IDEPTH];
   logic [3:0]         r_ttg [IDEPTH];
   logic [IAW-1:0]     r_twp;
   logic [IAW-1:0]     r_trp;
   logic [ICW-1:0]     r_tcnt;

   logic [3:0]         r_otg  [ODEPTH];
   logic signed [7:0]  r_ores [ODEPTH];
   logic [OAW-1:0]     r_owp;
   logic [OAW-1:0]     r_orp;
   logic [OCW-1:0]     r_ocnt;

   logic               w_tfull;
   logic               w_tpush;
   logic               w_pvalid;
   logic [TW-1:0]      w_pthr;
   logic               w_load;
   logic [TW-1:0]      w_lthr;
   logic [SW-1:0]      w_lcnt;
   logic               w_credit;
   logic               w_disp;
   logic               w_rpush;
   logic               w_rpop;

   assign w_tfull  = (r_tcnt == ICW'(IDEPTH));
   assign t_ready  = r_rdy & ~w_tfull;
   assign w_tpush  = t_valid & t_ready;
   assign w_pvalid = (int'(p_thread) < NTHREAD);
   assign w_pthr   = p_thread[TW-1:0];

   assign w_load = (r_state == S_START) |
                   ((r_state == S_RUN) & p_solved & w_pvalid);
   assign w_lthr = (r_state == S_START) ? r_cnt : w_pthr;

   always_comb begin
      w_lcnt = '0;
      for (int i = 0; i < NTHREAD; i++) begin
         w_lcnt = w_lcnt + SW'(r_live[i]);
      end
   end

   // Every live thread will eventually need a result slot.
   assign w_credit = (w_lcnt + SW'(r_ocnt)) < SW'(ODEPTH);
   assign w_disp   = w_load & (r_tcnt != '0) & w_credit;

   assign w_rpush = (r_state == S_RUN) & p_solved & w_pvalid &
                    r_live[w_pthr];
   assign w_rpop  = r_valid & r_ready;

   assign p_player   = w_disp ? r_tpl[r_trp] : '1;
   assign p_opponent = w_disp ? r_top[r_trp] : '0;
   assign p_enable   = r_pen;
   assign busy       = (r_state != S_IDLE);
   assign r_valid    = (r_ocnt != '0);
   assign r_tag      = r_otg[r_orp];
   assign r_res      = r_ores[r_orp];

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (run) w_next = S_START;
         S_START: if (r_cnt == TW'(NTHREAD - 1)) w_next = S_RUN;
         S_RUN:   if (!run && r_live == '0) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pen   <= 1'b0;
         r_rdy   <= 1'b0;
         r_live  <= '0;
      end else begin
         r_state <= w_next;
         r_pen   <= (w_next != S_IDLE);
         r_rdy   <= 1'b1;
         r_cnt   <= (r_state == S_START) ? r_cnt + TW'(1) : '0;
         if (w_load) r_live[w_lthr] <= w_disp;
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (w_disp) r_tagm[w_lthr] <= r_ttg[r_trp];
      if (w_tpush) begin
         r_tpl[r_twp] <= t_player;
         r_top[r_twp] <= t_opponent;
         r_ttg[r_twp] <= t_tag;
      end
      if (w_rpush) begin
         r_otg[r_owp]  <= r_tagm[w_pthr];
         r_ores[r_owp] <= p_res;
      end
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         r_twp  <= '0;
         r_trp  <= '0;
         r_tcnt <= '0;
      end else begin
         if (w_tpush)
            r_twp <= (r_twp == IAW'(IDEPTH - 1)) ? '0 : r_twp + IAW'(1);
         if (w_disp)
            r_trp <= (r_trp == IAW'(IDEPTH - 1)) ? '0 : r_trp + IAW'(1);
         r_tcnt <= r_tcnt + ICW'(w_tpush) - ICW'(w_disp);
      end
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         r_owp  <= '0;
         r_orp  <= '0;
         r_ocnt <= '0;
      end else begin
         if (w_rpush)
            r_owp <= (r_owp == OAW'(ODEPTH - 1)) ? '0 : r_owp + OAW'(1);
         if (w_rpop)
            r_orp <= (r_orp == OAW'(ODEPTH - 1)) ? '0 : r_orp + OAW'(1);
         r_ocnt <= r_ocnt + OCW'(w_rpush) - OCW'(w_rpop);
      end
   end

endmodule
